// File: rtl/rrf_wq.sv
// Retirement write queue: buffers up to three in-order register writes per cycle
// and issues them on two register-file write ports without same-address collisions.
module rrf_wq #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ADDR_LIMIT = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in0_vld,
  input  logic                  in1_vld,
  input  logic                  in2_vld,
  input  logic [5:0]            in0_addr,
  input  logic [5:0]            in1_addr,
  input  logic [5:0]            in2_addr,
  input  logic [DATA_WIDTH-1:0] in0_data,
  input  logic [DATA_WIDTH-1:0] in1_data,
  input  logic [DATA_WIDTH-1:0] in2_data,
  output logic                  in_rdy,
  input  logic                  drain_en,
  input  logic                  flush,
  output logic [5:0]            write0_addr,
  output logic [5:0]            write1_addr,
  output logic [DATA_WIDTH-1:0] write0_data,
  output logic [DATA_WIDTH-1:0] write1_data,
  output logic                  write0_wen,
  output logic                  write1_wen,
  output logic                  empty,
  output logic                  err_addr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] RDY_MAX = CNT_W'(DEPTH - 3);
  localparam logic [6:0]       LIMIT   = 7'(ADDR_LIMIT);

  function automatic logic addr_legal(input logic [5:0] a);
    return ({1'b0, a} < LIMIT);
  endfunction

  logic [5:0]            mem_addr_q [DEPTH];
  logic [5:0]            mem_addr_d [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_d [DEPTH];

  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  err_addr_q, err_addr_d;

  logic [5:0]            write0_addr_q, write0_addr_d;
  logic [5:0]            write1_addr_q, write1_addr_d;
  logic [DATA_WIDTH-1:0] write0_data_q, write0_data_d;
  logic [DATA_WIDTH-1:0] write1_data_q, write1_data_d;
  logic                  write0_wen_q, write0_wen_d;
  logic                  write1_wen_q, write1_wen_d;

  logic [2:0]            lane_vld;
  logic [5:0]            lane_addr [3];
  logic [DATA_WIDTH-1:0] lane_data [3];
  logic [2:0]            lane_ok;
  logic [2:0]            lane_bad;

  logic                  take;
  logic [1:0]            n_acc;
  logic [1:0]            n_pop;
  logic [PTR_W-1:0]      h0, h1;

  assign in_rdy = (count_q <= RDY_MAX);
  assign empty  = (count_q == '0);

  always_comb begin
    lane_vld     = {in2_vld, in1_vld, in0_vld};
    lane_addr[0] = in0_addr;
    lane_addr[1] = in1_addr;
    lane_addr[2] = in2_addr;
    lane_data[0] = in0_data;
    lane_data[1] = in1_data;
    lane_data[2] = in2_data;
    lane_ok      = '0;
    lane_bad     = '0;
    for (int i = 0; i < 3; i++) begin
      lane_ok[i]  = lane_vld[i] && addr_legal(lane_addr[i]);
      lane_bad[i] = lane_vld[i] && !addr_legal(lane_addr[i]);
    end
  end

  always_comb begin
    mem_addr_d    = mem_addr_q;
    mem_data_d    = mem_data_q;
    err_addr_d    = err_addr_q;
    write0_addr_d = '0;
    write0_data_d = '0;
    write0_wen_d  = 1'b0;
    write1_addr_d = '0;
    write1_data_d = '0;
    write1_wen_d  = 1'b0;
    n_acc         = '0;
    n_pop         = '0;
    take          = in_rdy && !flush;
    h0            = head_q;
    h1            = head_q + PTR_W'(1);

    // Legal lanes pack densely at the tail in lane order; dropped lanes leave no hole.
    for (int i = 0; i < 3; i++) begin
      if (take && lane_bad[i]) begin
        err_addr_d = 1'b1;
      end
      if (take && lane_ok[i]) begin
        mem_addr_d[tail_q + PTR_W'(n_acc)] = lane_addr[i];
        mem_data_d[tail_q + PTR_W'(n_acc)] = lane_data[i];
        n_acc = n_acc + 2'd1;
      end
    end

    // Pop decision looks only at registered count, so same-cycle arrivals wait a cycle.
    if (drain_en && !flush) begin
      if (count_q == CNT_W'(1)) begin
        n_pop         = 2'd1;
        write0_wen_d  = 1'b1;
        write0_addr_d = mem_addr_q[h0];
        write0_data_d = mem_data_q[h0];
      end else if (count_q >= CNT_W'(2)) begin
        n_pop = 2'd2;
        if (mem_addr_q[h0] != mem_addr_q[h1]) begin
          write0_wen_d  = 1'b1;
          write0_addr_d = mem_addr_q[h0];
          write0_data_d = mem_data_q[h0];
          write1_wen_d  = 1'b1;
          write1_addr_d = mem_addr_q[h1];
          write1_data_d = mem_data_q[h1];
        end else begin
          // Same target: the younger write supersedes the older one.
          write0_wen_d  = 1'b1;
          write0_addr_d = mem_addr_q[h1];
          write0_data_d = mem_data_q[h1];
        end
      end
    end

    head_d  = head_q + PTR_W'(n_pop);
    tail_d  = tail_q + PTR_W'(n_acc);
    count_d = count_q + CNT_W'(n_acc) - CNT_W'(n_pop);

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      err_addr_q    <= 1'b0;
      write0_addr_q <= '0;
      write0_data_q <= '0;
      write0_wen_q  <= 1'b0;
      write1_addr_q <= '0;
      write1_data_q <= '0;
      write1_wen_q  <= 1'b0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      err_addr_q    <= err_addr_d;
      write0_addr_q <= write0_addr_d;
      write0_data_q <= write0_data_d;
      write0_wen_q  <= write0_wen_d;
      write1_addr_q <= write1_addr_d;
      write1_data_q <= write1_data_d;
      write1_wen_q  <= write1_wen_d;
    end
  end

  // Entry storage carries no reset; validity is tracked by head/tail/count alone.
  always_ff @(posedge clk) begin
    mem_addr_q <= mem_addr_d;
    mem_data_q <= mem_data_d;
  end

  assign write0_addr = write0_addr_q;
  assign write0_data = write0_data_q;
  assign write0_wen  = write0_wen_q;
  assign write1_addr = write1_addr_q;
  assign write1_data = write1_data_q;
  assign write1_wen  = write1_wen_q;
  assign err_addr    = err_addr_q;

  a_no_port_collision: assert property (@(posedge clk) disable iff (!rst)
    !(write0_wen_q && write1_wen_q && (write0_addr_q == write1_addr_q)));

endmodule

// File: tb/tb_rrf_wq.sv
// Bench for rrf_wq: table of single-request vectors with per-cycle expectations,
// plus scoreboarded sequences for fill/wrap, flush, reset mid-drain and streaming.
module tb_rrf_wq;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in0_vld, in1_vld, in2_vld;
  logic [5:0]    in0_addr, in1_addr, in2_addr;
  logic [DW-1:0] in0_data, in1_data, in2_data;
  logic          in_rdy, drain_en, flush;
  logic [5:0]    write0_addr, write1_addr;
  logic [DW-1:0] write0_data, write1_data;
  logic          write0_wen, write1_wen, empty, err_addr;

  rrf_wq #(.DATA_WIDTH(DW), .DEPTH(8), .ADDR_LIMIT(40)) dut (
    .clk(clk), .rst(rst),
    .in0_vld(in0_vld), .in1_vld(in1_vld), .in2_vld(in2_vld),
    .in0_addr(in0_addr), .in1_addr(in1_addr), .in2_addr(in2_addr),
    .in0_data(in0_data), .in1_data(in1_data), .in2_data(in2_data),
    .in_rdy(in_rdy), .drain_en(drain_en), .flush(flush),
    .write0_addr(write0_addr), .write1_addr(write1_addr),
    .write0_data(write0_data), .write1_data(write1_data),
    .write0_wen(write0_wen), .write1_wen(write1_wen),
    .empty(empty), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]    addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic [2:0] vld;
    logic [5:0] a0, a1, a2;
    int         s1p0, s1p1, s2p0, s2p1;
    logic       err;
  } vec_t;

  wr_t  sb[$];
  bit   sb_on = 1'b0;
  int   n_vec = 0;
  int   n_fail = 0;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string p, input logic [5:0] a, input logic [DW-1:0] d);
    wr_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL sb_%s_unexpected: got write addr %0d data %0h, required no write", p, a, d);
    end else begin
      e = sb.pop_front();
      chk({"sb_", p, "_addr"}, 32'(a), 32'(e.addr));
      chk({"sb_", p, "_data"}, d, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (sb_on) begin
      if (write0_wen) sb_check("port0", write0_addr, write0_data);
      if (write1_wen) sb_check("port1", write1_addr, write1_data);
    end
  end

  task automatic drive(input logic [2:0] v, input logic [5:0] a0, input logic [5:0] a1,
                       input logic [5:0] a2, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [DW-1:0] d2);
    in0_vld = v[0]; in1_vld = v[1]; in2_vld = v[2];
    in0_addr = a0;  in1_addr = a1;  in2_addr = a2;
    in0_data = d0;  in1_data = d1;  in2_data = d2;
  endtask

  task automatic idle();
    in0_vld = 1'b0; in1_vld = 1'b0; in2_vld = 1'b0;
  endtask

  task automatic push(input logic [5:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; drain_en = 1'b0;
    idle();
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [DW-1:0] ld(input int v, input int l);
    return 32'hD000_0000 + 32'(v * 256 + l);
  endfunction

  function automatic logic [5:0] lane_addr(input int v, input int l);
    case (l)
      0:       return tbl[v].a0;
      1:       return tbl[v].a1;
      default: return tbl[v].a2;
    endcase
  endfunction

  task automatic check_ports(input int v, input string tag, input int l0, input int l1);
    chk($sformatf("v%0d_%s_p0_wen", v, tag), 32'(write0_wen), 32'(l0 >= 0));
    if (l0 >= 0) begin
      chk($sformatf("v%0d_%s_p0_addr", v, tag), 32'(write0_addr), 32'(lane_addr(v, l0)));
      chk($sformatf("v%0d_%s_p0_data", v, tag), write0_data, ld(v, l0));
    end
    chk($sformatf("v%0d_%s_p1_wen", v, tag), 32'(write1_wen), 32'(l1 >= 0));
    if (l1 >= 0) begin
      chk($sformatf("v%0d_%s_p1_addr", v, tag), 32'(write1_addr), 32'(lane_addr(v, l1)));
      chk($sformatf("v%0d_%s_p1_data", v, tag), write1_data, ld(v, l1));
    end
  endtask

  initial begin
    int m_cnt, k, acc, pop;
    logic rdy_exp;

    rst = 1'b0; flush = 1'b0; drain_en = 1'b0;
    drive(3'b000, 6'd0, 6'd0, 6'd0, '0, '0, '0);

    tbl[0] = '{3'b111, 6'd1,  6'd2,  6'd3,   0,  1,  2, -1, 1'b0};
    tbl[1] = '{3'b011, 6'd5,  6'd5,  6'd0,   1, -1, -1, -1, 1'b0};
    tbl[2] = '{3'b110, 6'd0,  6'd7,  6'd8,   1,  2, -1, -1, 1'b0};
    tbl[3] = '{3'b111, 6'd10, 6'd45, 6'd11,  0,  2, -1, -1, 1'b1};
    tbl[4] = '{3'b011, 6'd39, 6'd40, 6'd0,   0, -1, -1, -1, 1'b1};
    tbl[5] = '{3'b111, 6'd12, 6'd50, 6'd12,  2, -1, -1, -1, 1'b1};
    tbl[6] = '{3'b111, 6'd9,  6'd9,  6'd9,   1, -1,  2, -1, 1'b0};
    tbl[7] = '{3'b111, 6'd20, 6'd20, 6'd21,  1, -1,  2, -1, 1'b0};
    tbl[8] = '{3'b111, 6'd22, 6'd23, 6'd23,  0,  1,  2, -1, 1'b0};
    tbl[9] = '{3'b000, 6'd63, 6'd63, 6'd63, -1, -1, -1, -1, 1'b0};

    // Reset state
    do_reset();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_in_rdy", 32'(in_rdy), 32'd1);
    chk("rst_wen0", 32'(write0_wen), 32'd0);
    chk("rst_wen1", 32'(write1_wen), 32'd0);
    chk("rst_addr0", 32'(write0_addr), 32'd0);
    chk("rst_data0", write0_data, 32'd0);
    chk("rst_err", 32'(err_addr), 32'd0);

    // Single-cycle request vectors, each from reset
    for (int v = 0; v < 10; v++) begin
      do_reset();
      chk($sformatf("v%0d_err_after_rst", v), 32'(err_addr), 32'd0);
      drain_en = 1'b1;
      drive(tbl[v].vld, tbl[v].a0, tbl[v].a1, tbl[v].a2, ld(v, 0), ld(v, 1), ld(v, 2));
      @(negedge clk);
      idle();
      @(negedge clk);
      check_ports(v, "s1", tbl[v].s1p0, tbl[v].s1p1);
      @(negedge clk);
      check_ports(v, "s2", tbl[v].s2p0, tbl[v].s2p1);
      chk($sformatf("v%0d_err", v), 32'(err_addr), 32'(tbl[v].err));
      chk($sformatf("v%0d_empty", v), 32'(empty), 32'd1);
    end

    // Fill to full with drain held off, across pointer wrap
    do_reset();
    sb_on = 1'b1;
    drain_en = 1'b1;
    drive(3'b111, 6'd1, 6'd2, 6'd3, 32'hA1, 32'hA2, 32'hA3);
    push(6'd1, 32'hA1); push(6'd2, 32'hA2); push(6'd3, 32'hA3);
    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
    drain_en = 1'b0;
    chk("full_rdy_0", 32'(in_rdy), 32'd1);
    drive(3'b111, 6'd30, 6'd31, 6'd32, 32'hE0, 32'hE1, 32'hE2);
    push(6'd30, 32'hE0); push(6'd31, 32'hE1); push(6'd32, 32'hE2);
    @(negedge clk);
    chk("full_rdy_3", 32'(in_rdy), 32'd1);
    drive(3'b111, 6'd33, 6'd34, 6'd35, 32'hE3, 32'hE4, 32'hE5);
    push(6'd33, 32'hE3); push(6'd34, 32'hE4); push(6'd35, 32'hE5);
    @(negedge clk);
    chk("full_rdy_6", 32'(in_rdy), 32'd0);
    drive(3'b111, 6'd36, 6'd37, 6'd38, 32'hEE, 32'hEE, 32'hEE);
    @(negedge clk);
    chk("full_rdy_held", 32'(in_rdy), 32'd0);
    chk("full_not_empty", 32'(empty), 32'd0);
    @(negedge clk);
    idle();
    drain_en = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("full_sb_after2", 32'(sb.size()), 32'd2);
    repeat (3) @(negedge clk);
    #1;
    chk("full_sb_drained", 32'(sb.size()), 32'd0);
    chk("full_empty", 32'(empty), 32'd1);
    sb_on = 1'b0;

    // Flush with a queued backlog and a simultaneous new request
    do_reset();
    sb_on = 1'b1;
    drive(3'b111, 6'd1, 6'd2, 6'd3, 32'hB1, 32'hB2, 32'hB3);
    @(negedge clk);
    drive(3'b011, 6'd4, 6'd5, 6'd0, 32'hB4, 32'hB5, 32'hB6);
    @(negedge clk);
    chk("fl_not_empty", 32'(empty), 32'd0);
    flush = 1'b1;
    drain_en = 1'b1;
    drive(3'b111, 6'd6, 6'd7, 6'd50, 32'hC6, 32'hC7, 32'hC8);
    @(negedge clk);
    flush = 1'b0;
    idle();
    chk("fl_wen0", 32'(write0_wen), 32'd0);
    chk("fl_wen1", 32'(write1_wen), 32'd0);
    chk("fl_empty", 32'(empty), 32'd1);
    chk("fl_in_rdy", 32'(in_rdy), 32'd1);
    chk("fl_err", 32'(err_addr), 32'd0);
    repeat (4) @(negedge clk);
    chk("fl_still_empty", 32'(empty), 32'd1);
    drive(3'b001, 6'd9, 6'd0, 6'd0, 32'hD9, 32'h0, 32'h0);
    push(6'd9, 32'hD9);
    @(negedge clk);
    idle();
    repeat (2) @(negedge clk);
    #1;
    chk("fl_post_sb", 32'(sb.size()), 32'd0);
    sb_on = 1'b0;

    // Reset while writes are issuing
    do_reset();
    drain_en = 1'b1;
    drive(3'b111, 6'd11, 6'd12, 6'd13, 32'hF1, 32'hF2, 32'hF3);
    @(negedge clk);
    drive(3'b111, 6'd14, 6'd15, 6'd16, 32'hF4, 32'hF5, 32'hF6);
    @(negedge clk);
    idle();
    chk("rmd_wen_before", 32'(write0_wen), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("rmd_wen0", 32'(write0_wen), 32'd0);
    chk("rmd_wen1", 32'(write1_wen), 32'd0);
    chk("rmd_addr0", 32'(write0_addr), 32'd0);
    chk("rmd_addr1", 32'(write1_addr), 32'd0);
    chk("rmd_data0", write0_data, 32'd0);
    chk("rmd_data1", write1_data, 32'd0);
    chk("rmd_empty", 32'(empty), 32'd1);
    chk("rmd_in_rdy", 32'(in_rdy), 32'd1);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rmd_quiet_%0d", c), 32'({write1_wen, write0_wen}), 32'd0);
    end

    // Continuous 3-wide stream with concurrent drain
    do_reset();
    sb_on = 1'b1;
    drain_en = 1'b1;
    m_cnt = 0;
    k = 0;
    for (int c = 0; c < 14; c++) begin
      rdy_exp = (m_cnt <= 5);
      chk($sformatf("strm_rdy_%0d", c), 32'(in_rdy), 32'(rdy_exp));
      drive(3'b111, 6'(k % 40), 6'((k + 1) % 40), 6'((k + 2) % 40),
            32'h5000 + 32'(k), 32'h5000 + 32'(k + 1), 32'h5000 + 32'(k + 2));
      pop = (m_cnt >= 2) ? 2 : m_cnt;
      acc = 0;
      if (rdy_exp) begin
        push(6'(k % 40), 32'h5000 + 32'(k));
        push(6'((k + 1) % 40), 32'h5000 + 32'(k + 1));
        push(6'((k + 2) % 40), 32'h5000 + 32'(k + 2));
        k = k + 3;
        acc = 3;
      end
      m_cnt = m_cnt + acc - pop;
      @(negedge clk);
    end
    idle();
    repeat (6) @(negedge clk);
    #1;
    chk("strm_sb_drained", 32'(sb.size()), 32'd0);
    chk("strm_empty", 32'(empty), 32'd1);
    sb_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/rrf_wq.md
# rrf_wq

Retirement write queue and scheduler for the retirement register file. It accepts up to three architectural-register write requests per cycle from the retire stage and buffers them in order. It then issues them onto two register-file write ports, guaranteeing that both ports never target the same address in one cycle. The register file requires this because its per-entry write select is wired-OR across ports. It sits between the retire logic and the register-file write ports 0..1, and adds a flush path for pipeline recovery.

## Interface
- DATA_WIDTH, `alu_width`, payload width per write
- DEPTH, 8, queue entries; power of two, at least 4
- ADDR_LIMIT, 40, number of implemented register addresses; addresses >= ADDR_LIMIT are illegal
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset)
- in0_vld, in1_vld, in2_vld  in  1 each  request valid, lane 0 oldest
- in0_addr, in1_addr, in2_addr  in  6 each  target register address
- in0_data, in1_data, in2_data  in  DATA_WIDTH each  write payload
- in_rdy  out  1  queue can take 3 requests this cycle
- drain_en  in  1  register file may accept writes this cycle
- flush  in  1  discard all queued and not-yet-issued writes
- write0_addr, write1_addr  out  6 each  register-file write address, registered
- write0_data, write1_data  out  DATA_WIDTH each  register-file write data, registered
- write0_wen, write1_wen  out  1 each  write enables, registered
- empty  out  1  queue holds no entries
- err_addr  out  1  sticky: an illegal address was presented and dropped

## Operation
- Storage: circular buffer of DEPTH entries {addr, data}, with head pointer, tail pointer and count (0..DEPTH). Pointers wrap modulo DEPTH.
- in_rdy = (DEPTH - count) >= 3, computed from registered count.
- Accept: when in_rdy=1 and flush=0, every valid lane with addr < ADDR_LIMIT is written at the tail, compacted in lane order (0, 1, 2).
  - Invalid lanes leave no gap in the queue.
  - When in_rdy=0, inputs are ignored; the sender must hold them.
- Illegal address: a valid lane with addr >= ADDR_LIMIT, while in_rdy=1, is dropped and sets err_addr. err_addr is cleared only by reset.
- Drain decision, made each cycle when drain_en=1 and flush=0, on the oldest entries H0 and H1:
  - count=0: pop 0; no write.
  - count=1: pop 1; H0 goes to port 0.
  - count>=2 and H0.addr != H1.addr: pop 2; H0 goes to port 0, H1 goes to port 1.
  - count>=2 and H0.addr == H1.addr: pop 2; H1 goes to port 0, port 1 is idle. The younger write wins and the older write is discarded (coalesce).
- The selected writes load the write*_ registers. The wen of an unused port is 0.
- drain_en=0: pop 0; next-cycle write0_wen and write1_wen are 0; queue contents are held.
- count_next = count + accepted - popped. Accept and pop in the same cycle are both legal. An entry accepted this cycle cannot be popped this cycle.
- flush=1: the next state has count=0, head=tail=0, and both wen=0. No accept occurs that cycle. err_addr is unaffected. Flush wins over accept and drain.
- Reset (rst=0): count=0, head=tail=0, all write*_ outputs 0, err_addr=0, so empty=1 and in_rdy=1 right after reset. Reset mid-operation drops all contents.

## Timing
- Request accepted at edge E is eligible to drain at edge E+1. Its wen is visible in the cycle after E+1, so minimum latency is 2 edges.
- Throughput: 3 writes in and 2 writes out per cycle. With continuous 3-wide input, in_rdy deasserts once count exceeds DEPTH-3.
- All outputs are registered. in_rdy and empty are derived from count only, with no combinational path from inputs.
- Write ordering to the same address is preserved across cycles: an older write never issues after a younger one.

## Test plan
- Reset, then in0/in1/in2 = addr 1/2/3, data A/B/C, one cycle:
  - cycle+2: port0 = (1,A), port1 = (2,B).
  - cycle+3: port0 = (3,C), port1 wen=0.
  - empty=1 afterwards.
- Coalesce: in0 = (5,X), in1 = (5,Y) -> a single write, port0 = (5,Y), write1_wen=0.
- Full: drain_en=0, feed 3-wide until in_rdy=0:
  - count=6 when in_rdy drops at DEPTH=8.
  - Inputs offered while in_rdy=0 are not enqueued.
  - Raise drain_en: 6 writes come out in order over 3 cycles, including across pointer wrap.
- Illegal address: in1 addr 45, lanes 0 and 2 legal -> only 2 entries queued and err_addr=1 stays high; after reset it reads 0.
- Flush: queue 5 entries, assert flush together with a new valid request:
  - Next cycle count=0 and wen=0.
  - The new request is not queued.
  - No write from before the flush ever appears.
- Reset mid-drain: drive rst=0 while wen=1 -> all outputs are 0 on the next edge, empty=1, in_rdy=1.
